adsr_envelope_ctrl: RTL and testbench
=====================================

Name: adsr_envelope_ctrl

Overview:
- Per-voice ADSR envelope sequencer. Advances one step per 44.1 kHz sample strobe from the shared frequency divider.
- Walks an 8.8 fixed-point index through the attack, decay, sustain and release phases.
- Addresses the external 256x8 exponential lookup ROM with the index integer part and registers the ROM word as the envelope output.
- Sits between the note gate source and the VCA multiplier.

Parameters:
- IDX_W, 16, index accumulator width (8 integer + 8 fraction bits; fixed at 16, exposed for lint only)
- MIN_TICK_GAP, 3, minimum clk cycles between sample_tick pulses that the block supports

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous reset, active-high
- sample_tick  in  1  one-clk strobe, 44.1 kHz
- gate  in  1  note on (1) / off (0), level
- attack_rate  in  8  index increment per tick; 0 = instant
- decay_rate  in  8  index decrement per tick; 0 = instant
- sustain_level  in  8  sustain index, integer part
- release_rate  in  8  index decrement per tick; 0 = instant
- rom_addr  out  8  exp ROM address, = idx[15:8]
- rom_data  in  8  exp ROM word; synchronous ROM, 1-clk read latency
- env_out  out  8  envelope value, registered
- env_valid  out  1  one-clk pulse when env_out updates
- state  out  3  0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
- busy  out  1  state != IDLE

Behaviour:
- Reset values: state=IDLE, idx=0, rom_addr=0, env_out=0, env_valid=0, busy=0. Reset overrides everything, including a tick in the same cycle.
- All inputs other than rst are evaluated only on cycles where sample_tick=1.
- Between ticks, idx and state hold.
- Rate inputs are zero-extended to 16 bits.
- Transitions and index update, evaluated at a tick (first matching rule wins):
  - IDLE, gate=1: go to ATTACK. idx is not modified on this tick.
  - ATTACK, gate=0: go to RELEASE. idx unchanged.
  - ATTACK: s = idx + attack_rate (17-bit). If s >= 0xFF00 or attack_rate=0, then idx = 0xFF00 and go to DECAY. Otherwise idx = s.
  - DECAY, gate=0: go to RELEASE.
  - DECAY: t = {sustain_level, 8'h00}, d = idx - decay_rate. If decay_rate=0, borrow, or d <= t, then idx = t and go to SUSTAIN. Otherwise idx = d.
  - SUSTAIN, gate=0: go to RELEASE.
  - SUSTAIN: idx = {sustain_level, 8'h00} reloaded every tick, so live sustain changes are tracked.
  - RELEASE, gate=1: retrigger. Go to ATTACK from the current idx with no reset to 0, so there is no click.
  - RELEASE: d = idx - release_rate. If release_rate=0, borrow, or d == 0, then idx = 0 and go to IDLE. Otherwise idx = d.
- Pipeline, with tick sampled at edge E0:
  - E0: idx/state updated.
  - rom_addr is combinational from the idx register.
  - E1: ROM registers rom_data.
  - E2: env_out <= (state==IDLE) ? 0 : rom_data, and env_valid=1 for the cycle after E2.
  - Latency is 2 clk from the tick edge.
- env_valid pulses exactly once per sample_tick, including ticks in IDLE, where env_out=0.
- Ticks closer than MIN_TICK_GAP cycles are unsupported. A bench assertion flags them.
- Attack saturates at 0xFF00, so idx never wraps. Decay and release clamp and never underflow.
- sustain_level=0xFF: DECAY exits to SUSTAIN on its first tick with idx=0xFF00.
- sustain_level=0: a gate held high ends in SUSTAIN with env_out=rom[0]. state remains SUSTAIN, not IDLE.

Test Plan:
1. Identity ROM (rom[i]=i), attack_rate=0x80, gate=1 from tick 0.
   - ATTACK entered at tick 0.
   - After attack tick k, env_out = k/2.
   - Tick 510 reaches 0xFF00, giving state=DECAY and env_out=0xFF.
   - env_valid is 2 clk after each tick.
2. Continue with decay_rate=0x40, sustain_level=0x80.
   - SUSTAIN entered after 508 decay ticks, env_out=0x80.
   - Then change sustain_level to 0x60: env_out=0x60 one tick later.
3. gate=0 in SUSTAIN (idx 0x6000), release_rate=0x100 cap → use 0xFF.
   - idx falls by 0xFF per tick; IDLE after 97 ticks.
   - env_out=0 and busy=0 from then on.
4. Retrigger: gate 1→0 mid-attack at idx 0x4000, then gate=1 again two ticks into release.
   - ATTACK resumes from idx 0x3E02 (rate 0xFF) with no drop to 0.
5. Instant rates: all rates=0, sustain_level=0x40, gate pulse.
   - Tick sequence gives states ATTACK, DECAY, SUSTAIN with env_out 0xFF, then 0x40.
   - On gate low: RELEASE, then IDLE with env_out=0.
6. rst=1 coincident with a tick during ATTACK.
   - Next cycle: state=IDLE, rom_addr=0, env_out=0, and no env_valid for that tick.

Source files
------------

// File: rtl/adsr_envelope_ctrl.sv
// rtl/adsr_envelope_ctrl.sv - per-voice ADSR envelope sequencer driving an exp lookup ROM
//
// Steps an 8.8 fixed-point index through attack/decay/sustain/release once per
// sample_tick, addresses the external exponential ROM with the index integer
// part and registers the returned word as the envelope value.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   sample_tick    one-clk sample strobe
//   gate           note on (1) / off (0)
//   attack_rate    index increment per tick, 0 = instant
//   decay_rate     index decrement per tick, 0 = instant
//   sustain_level  sustain index, integer part
//   release_rate   index decrement per tick, 0 = instant
//   rom_addr       exp ROM address (idx integer part)
//   rom_data       exp ROM word, 1-clk read latency
//   env_out        registered envelope value
//   env_valid      one-clk pulse when env_out updates
//   state          0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
//   busy           state != IDLE

module adsr_envelope_ctrl #(
  parameter int IDX_W        = 16,
  parameter int MIN_TICK_GAP = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_tick,
  input  logic       gate,
  input  logic [7:0] attack_rate,
  input  logic [7:0] decay_rate,
  input  logic [7:0] sustain_level,
  input  logic [7:0] release_rate,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] env_out,
  output logic       env_valid,
  output logic [2:0] state,
  output logic       busy
);

  // The index format is fixed 8.8 and the output pipeline is three stages
  // deep, so other values of these parameters are rejected at elaboration.
  if (IDX_W != 16) begin : g_bad_idx_w
    $error("adsr_envelope_ctrl: IDX_W must be 16");
  end
  if (MIN_TICK_GAP < 3) begin : g_bad_tick_gap
    $error("adsr_envelope_ctrl: MIN_TICK_GAP must be at least 3");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] IDX_PEAK = 16'hFF00;

  state_t           cur_state, nxt_state;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [IDX_W-1:0] sus_idx;
  logic [IDX_W:0]   att_sum;
  logic [IDX_W:0]   dec_diff;
  logic [IDX_W:0]   rel_diff;
  logic             tick_d1, tick_d2;

  // 17-bit arithmetic: bit 16 is the carry of the attack sum and the borrow of
  // the decay/release differences, which is how the index clamps instead of
  // wrapping.
  assign sus_idx  = {sustain_level, 8'h00};
  assign att_sum  = {1'b0, idx} + {9'b0, attack_rate};
  assign dec_diff = {1'b0, idx} - {9'b0, decay_rate};
  assign rel_diff = {1'b0, idx} - {9'b0, release_rate};

  always_comb begin
    nxt_state = cur_state;
    idx_nxt   = idx;
    if (sample_tick) begin
      case (cur_state)
        S_IDLE: begin
          if (gate) nxt_state = S_ATTACK;
        end
        S_ATTACK: begin
          if (!gate) begin
            nxt_state = S_RELEASE;
          end else if (attack_rate == 8'd0 || att_sum >= {1'b0, IDX_PEAK}) begin
            idx_nxt   = IDX_PEAK;
            nxt_state = S_DECAY;
          end else begin
            idx_nxt = att_sum[IDX_W-1:0];
          end
        end
        S_DECAY: begin
          if (!gate) begin
            nxt_state = S_RELEASE;
          end else if (decay_rate == 8'd0 || dec_diff[IDX_W] ||
                       dec_diff[IDX_W-1:0] <= sus_idx) begin
            idx_nxt   = sus_idx;
            nxt_state = S_SUSTAIN;
          end else begin
            idx_nxt = dec_diff[IDX_W-1:0];
          end
        end
        S_SUSTAIN: begin
          // Reloaded every tick so a live sustain_level change is followed.
          if (!gate) nxt_state = S_RELEASE;
          else       idx_nxt   = sus_idx;
        end
        S_RELEASE: begin
          // Retrigger keeps the current index so the attack ramps up from
          // where the release left off, avoiding a click.
          if (gate) begin
            nxt_state = S_ATTACK;
          end else if (release_rate == 8'd0 || rel_diff[IDX_W] ||
                       rel_diff[IDX_W-1:0] == '0) begin
            idx_nxt   = '0;
            nxt_state = S_IDLE;
          end else begin
            idx_nxt = rel_diff[IDX_W-1:0];
          end
        end
        default: begin
          nxt_state = S_IDLE;
          idx_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_IDLE;
      idx       <= '0;
      tick_d1   <= 1'b0;
      tick_d2   <= 1'b0;
      env_valid <= 1'b0;
      env_out   <= 8'd0;
    end else begin
      cur_state <= nxt_state;
      idx       <= idx_nxt;
      // tick_d1: ROM is sampling the new address; tick_d2: rom_data is valid.
      tick_d1   <= sample_tick;
      tick_d2   <= tick_d1;
      env_valid <= tick_d2;
      if (tick_d2) begin
        env_out <= (cur_state == S_IDLE) ? 8'd0 : rom_data;
      end
    end
  end

  assign rom_addr = idx[IDX_W-1:8];
  assign state    = cur_state;
  assign busy     = (cur_state != S_IDLE);

endmodule

// File: tb/tb_adsr_envelope_ctrl.sv
// tb/tb_adsr_envelope_ctrl.sv - directed self-checking bench for adsr_envelope_ctrl

module tb_adsr_envelope_ctrl;

  localparam int MIN_GAP = 3;

  logic       clk;
  logic       rst;
  logic       sample_tick;
  logic       gate;
  logic [7:0] attack_rate;
  logic [7:0] decay_rate;
  logic [7:0] sustain_level;
  logic [7:0] release_rate;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] env_out;
  logic       env_valid;
  logic [2:0] state;
  logic       busy;

  int passed;
  int total;
  int since_tick;

  adsr_envelope_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .env_out       (env_out),
    .env_valid     (env_valid),
    .state         (state),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Identity exponential ROM with one clock of read latency.
  always @(posedge clk) rom_data <= rom_addr;

  initial since_tick = 1000;
  always @(posedge clk) begin
    if (sample_tick && !rst)
      assert (since_tick >= MIN_GAP) else $error("sample_tick gap too short: %0d", since_tick);
    if (sample_tick) since_tick <= 1;
    else if (since_tick < 1000) since_tick <= since_tick + 1;
  end

  // Starts and ends on a negedge. Returns the state right after the tick edge,
  // env_valid one cycle after the tick (must be low), env_valid and env_out
  // two cycles after the tick.
  task automatic do_tick(output logic [2:0] st, output logic ev_early,
                         output logic ev, output logic [7:0] eo);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    st = state;
    @(negedge clk);
    ev_early = env_valid;
    @(negedge clk);
    ev = env_valid;
    eo = env_out;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (state !== 3'd0) $display("FAIL reset_state got %0d want 0", state); else passed++;
    total++; if (rom_addr !== 8'd0) $display("FAIL reset_rom_addr got %0h want 0", rom_addr); else passed++;
    total++; if (env_out !== 8'd0) $display("FAIL reset_env_out got %0h want 0", env_out); else passed++;
    total++; if (env_valid !== 1'b0) $display("FAIL reset_env_valid got %0b want 0", env_valid); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_idle_tick;
    logic [2:0] st; logic e0, e1; logic [7:0] eo;
    gate = 1'b0;
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd0) $display("FAIL idle_tick_state got %0d want 0", st); else passed++;
    total++; if (e1 !== 1'b1 || eo !== 8'd0)
      $display("FAIL idle_tick_env got valid=%0b env=%0h want valid=1 env=0", e1, eo); else passed++;
  endtask

  task automatic test_attack;
    logic [2:0] st; logic e0, e1; logic [7:0] eo;
    attack_rate = 8'h80; gate = 1'b1;
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd1) $display("FAIL attack_enter got %0d want 1", st); else passed++;
    total++; if (e0 !== 1'b0 || e1 !== 1'b1)
      $display("FAIL attack_latency got early=%0b late=%0b want 0 1", e0, e1); else passed++;
    total++; if (eo !== 8'd0) $display("FAIL attack_tick0_env got %0h want 0", eo); else passed++;
    for (int k = 1; k <= 509; k++) begin
      do_tick(st, e0, e1, eo);
      total++;
      if (st !== 3'd1 || eo !== 8'(k / 2) || e0 !== 1'b0 || e1 !== 1'b1)
        $display("FAIL attack_ramp k=%0d got st=%0d env=%0h v=%0b%0b want st=1 env=%0h v=01",
                 k, st, eo, e0, e1, k / 2);
      else passed++;
    end
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd2 || eo !== 8'hFF)
      $display("FAIL attack_peak got st=%0d env=%0h want st=2 env=ff", st, eo); else passed++;
  endtask

  task automatic test_decay_sustain;
    logic [2:0] st; logic e0, e1; logic [7:0] eo;
    decay_rate = 8'h40; sustain_level = 8'h80;
    for (int k = 1; k <= 507; k++) begin
      do_tick(st, e0, e1, eo);
      total++;
      if (st !== 3'd2 || eo !== 8'((65280 - 64 * k) / 256))
        $display("FAIL decay_ramp k=%0d got st=%0d env=%0h want st=2 env=%0h",
                 k, st, eo, (65280 - 64 * k) / 256);
      else passed++;
    end
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd3 || eo !== 8'h80)
      $display("FAIL decay_to_sustain got st=%0d env=%0h want st=3 env=80", st, eo); else passed++;
    sustain_level = 8'h60;
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd3 || eo !== 8'h60)
      $display("FAIL sustain_track got st=%0d env=%0h want st=3 env=60", st, eo); else passed++;
  endtask

  task automatic test_release;
    logic [2:0] st; logic e0, e1; logic [7:0] eo;
    release_rate = 8'hFF; gate = 1'b0;
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd4 || eo !== 8'h60)
      $display("FAIL release_enter got st=%0d env=%0h want st=4 env=60", st, eo); else passed++;
    for (int k = 1; k <= 96; k++) begin
      do_tick(st, e0, e1, eo);
      total++;
      if (st !== 3'd4 || eo !== 8'((24576 - 255 * k) / 256))
        $display("FAIL release_ramp k=%0d got st=%0d env=%0h want st=4 env=%0h",
                 k, st, eo, (24576 - 255 * k) / 256);
      else passed++;
    end
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd0 || eo !== 8'd0 || busy !== 1'b0)
      $display("FAIL release_end got st=%0d env=%0h busy=%0b want 0 0 0", st, eo, busy); else passed++;
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd0 || eo !== 8'd0 || e1 !== 1'b1)
      $display("FAIL idle_after_release got st=%0d env=%0h v=%0b want 0 0 1", st, eo, e1); else passed++;
  endtask

  task automatic test_retrigger;
    logic [2:0] st; logic e0, e1; logic [7:0] eo;
    attack_rate = 8'h80; release_rate = 8'hFF; gate = 1'b1;
    do_tick(st, e0, e1, eo);
    for (int k = 1; k <= 128; k++) do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd1 || eo !== 8'h40)
      $display("FAIL retrig_attack got st=%0d env=%0h want st=1 env=40", st, eo); else passed++;
    gate = 1'b0;
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd4 || eo !== 8'h40)
      $display("FAIL retrig_release got st=%0d env=%0h want st=4 env=40", st, eo); else passed++;
    do_tick(st, e0, e1, eo);
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd4 || eo !== 8'h3E)
      $display("FAIL retrig_release2 got st=%0d env=%0h want st=4 env=3e", st, eo); else passed++;
    gate = 1'b1;
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd1 || eo !== 8'h3E || rom_addr !== 8'h3E)
      $display("FAIL retrig_resume got st=%0d env=%0h addr=%0h want st=1 env=3e addr=3e",
               st, eo, rom_addr); else passed++;
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd1 || eo !== 8'h3E)
      $display("FAIL retrig_ramp got st=%0d env=%0h want st=1 env=3e", st, eo); else passed++;
    release_rate = 8'h00; gate = 1'b0;
    do_tick(st, e0, e1, eo);
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd0 || eo !== 8'd0)
      $display("FAIL retrig_to_idle got st=%0d env=%0h want 0 0", st, eo); else passed++;
  endtask

  task automatic test_instant;
    logic [2:0] st; logic e0, e1; logic [7:0] eo;
    logic [2:0] exp_st [5];
    logic [7:0] exp_eo [5];
    exp_st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    exp_eo = '{8'h00, 8'hFF, 8'h40, 8'h40, 8'h00};
    attack_rate = 8'h00; decay_rate = 8'h00; release_rate = 8'h00; sustain_level = 8'h40;
    for (int i = 0; i < 5; i++) begin
      gate = (i < 3);
      do_tick(st, e0, e1, eo);
      total++;
      if (st !== exp_st[i] || eo !== exp_eo[i])
        $display("FAIL instant step=%0d got st=%0d env=%0h want st=%0d env=%0h",
                 i, st, eo, exp_st[i], exp_eo[i]);
      else passed++;
    end
  endtask

  task automatic test_sustain_limits;
    logic [2:0] st; logic e0, e1; logic [7:0] eo;
    attack_rate = 8'h00; decay_rate = 8'h10; sustain_level = 8'hFF; gate = 1'b1;
    do_tick(st, e0, e1, eo);
    do_tick(st, e0, e1, eo);
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd3 || eo !== 8'hFF)
      $display("FAIL sustain_ff got st=%0d env=%0h want st=3 env=ff", st, eo); else passed++;
    sustain_level = 8'h00;
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd3 || eo !== 8'h00 || busy !== 1'b1)
      $display("FAIL sustain_zero got st=%0d env=%0h busy=%0b want st=3 env=0 busy=1",
               st, eo, busy); else passed++;
    gate = 1'b0;
    do_tick(st, e0, e1, eo);
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd0)
      $display("FAIL sustain_zero_release got st=%0d want 0", st); else passed++;
  endtask

  task automatic test_reset_on_tick;
    logic [2:0] st; logic e0, e1; logic [7:0] eo;
    attack_rate = 8'h80; gate = 1'b1;
    do_tick(st, e0, e1, eo);
    do_tick(st, e0, e1, eo);
    do_tick(st, e0, e1, eo);
    total++; if (st !== 3'd1 || eo !== 8'h01)
      $display("FAIL pre_reset got st=%0d env=%0h want st=1 env=1", st, eo); else passed++;
    sample_tick = 1'b1; rst = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0; rst = 1'b0;
    total++; if (state !== 3'd0 || rom_addr !== 8'd0 || env_out !== 8'd0 || busy !== 1'b0)
      $display("FAIL reset_tick got st=%0d addr=%0h env=%0h busy=%0b want all 0",
               state, rom_addr, env_out, busy); else passed++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (env_valid !== 1'b0 || env_out !== 8'd0)
        $display("FAIL reset_tick_valid cyc=%0d got v=%0b env=%0h want 0 0", i, env_valid, env_out);
      else passed++;
    end
  endtask

  initial begin
    passed = 0; total = 0;
    rst = 1'b1; sample_tick = 1'b0; gate = 1'b0;
    attack_rate = 8'h00; decay_rate = 8'h00; sustain_level = 8'h00; release_rate = 8'h00;
    test_reset();
    test_idle_tick();
    test_attack();
    test_decay_sustain();
    test_release();
    test_retrigger();
    test_instant();
    test_sustain_limits();
    test_reset_on_tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
